wb_commit_queue: RTL and testbench

//   Writeback commit queue feeding the RegisterFile write port. Collects results

---
 rtl/wb_commit_queue_if.sv | 56 +++++
 rtl/wb_commit_queue.sv | 93 +++++++++
 tb/tb_wb_commit_queue.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_queue_if.sv
// Bundle of the writeback commit queue's producer, register-file and forwarding
// signals. The queue itself connects through the slave modport.
interface wb_commit_queue_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   // ALU result channel
   logic          alu_valid;
   logic          alu_ready;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;

   // Load result channel
   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_rd;
   logic [DW-1:0] ld_data;

   // RegisterFile write port
   logic          rf_write_en;
   logic [AW-1:0] rf_write_address;
   logic [DW-1:0] rf_write_data;

   // Decode-side forwarding
   logic [AW-1:0] fwd_addr_0;
   logic [AW-1:0] fwd_addr_1;
   logic          fwd_hit_0;
   logic          fwd_hit_1;
   logic [DW-1:0] fwd_data_0;
   logic [DW-1:0] fwd_data_1;

   logic [CW-1:0] count;

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      input  fwd_addr_0, fwd_addr_1,
      output alu_ready, ld_ready,
      output rf_write_en, rf_write_address, rf_write_data,
      output fwd_hit_0, fwd_hit_1, fwd_data_0, fwd_data_1,
      output count
   );

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      output fwd_addr_0, fwd_addr_1,
      input  alu_ready, ld_ready,
      input  rf_write_en, rf_write_address, rf_write_data,
      input  fwd_hit_0, fwd_hit_1, fwd_data_0, fwd_data_1,
      input  count
   );
endinterface

// File: rtl/wb_commit_queue.sv
// In-order writeback queue: accepts ALU and load results, drains one register
// write per cycle, and forwards the youngest queued value to two decode reads.
module wb_commit_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_commit_queue_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] r_rd_mem   [DEPTH];
   logic [DW-1:0] r_data_mem [DEPTH];
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_wptr;
   logic [CW-1:0] r_count;

   logic          w_pop;
   logic [CW:0]   w_free;
   logic          w_alu_ready;
   logic          w_ld_ready;
   logic          w_alu_push;
   logic          w_ld_push;
   logic [PW-1:0] w_ld_slot;
   logic [PW-1:0] w_idx;

   assign w_pop  = (r_count != '0);
   assign w_free = (CW+1)'(DEPTH) - (CW+1)'(r_count) + (CW+1)'(w_pop);

   // A load sharing the cycle with a valid ALU result needs a second slot,
   // even when the ALU targets r0 and ends up not occupying one.
   assign w_alu_ready = (w_free != '0);
   assign w_ld_ready  = bus.alu_valid ? (w_free >= (CW+1)'(2)) : (w_free != '0);

   assign w_alu_push = bus.alu_valid & w_alu_ready & (bus.alu_rd != '0);
   assign w_ld_push  = bus.ld_valid  & w_ld_ready  & (bus.ld_rd  != '0);
   assign w_ld_slot  = r_wptr + PW'(w_alu_push);

   assign bus.alu_ready        = w_alu_ready;
   assign bus.ld_ready         = w_ld_ready;
   assign bus.rf_write_en      = w_pop;
   assign bus.rf_write_address = w_pop ? r_rd_mem[r_rptr]   : '0;
   assign bus.rf_write_data    = w_pop ? r_data_mem[r_rptr] : '0;
   assign bus.count            = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         r_rptr  <= r_rptr + PW'(w_pop);
         r_wptr  <= r_wptr + PW'(w_alu_push) + PW'(w_ld_push);
         r_count <= r_count + CW'(w_alu_push) + CW'(w_ld_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_alu_push) begin
         r_rd_mem[r_wptr]   <= bus.alu_rd;
         r_data_mem[r_wptr] <= bus.alu_data;
      end
      if (w_ld_push) begin
         r_rd_mem[w_ld_slot]   <= bus.ld_rd;
         r_data_mem[w_ld_slot] <= bus.ld_data;
      end
   end

   // Scan oldest to youngest so the last match wins.
   always_comb begin
      bus.fwd_hit_0  = 1'b0;
      bus.fwd_hit_1  = 1'b0;
      bus.fwd_data_0 = '0;
      bus.fwd_data_1 = '0;
      w_idx          = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_idx = r_rptr + PW'(i);
         if (CW'(i) < r_count) begin
            if ((bus.fwd_addr_0 != '0) && (r_rd_mem[w_idx] == bus.fwd_addr_0)) begin
               bus.fwd_hit_0  = 1'b1;
               bus.fwd_data_0 = r_data_mem[w_idx];
            end
            if ((bus.fwd_addr_1 != '0) && (r_rd_mem[w_idx] == bus.fwd_addr_1)) begin
               bus.fwd_hit_1  = 1'b1;
               bus.fwd_data_1 = r_data_mem[w_idx];
            end
         end
      end
   end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: accepted entries are queued as they are
// driven and matched against every register-file write.
module tb_wb_commit_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int unsigned m_count;
   bit   last_a_acc;
   bit   last_l_acc;
   ent_t sb[$];

   wb_commit_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) cq ();

   wb_commit_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (cq)
   );

   always #5 clk = ~clk;

   // Commit monitor: every write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      ent_t e;
      checks++;
      if (cq.rf_write_en !== (sb.size() != 0)) begin
         errors++;
         $display("FAIL commit_en: got %b expected %b", cq.rf_write_en, (sb.size() != 0));
      end
      if (cq.rf_write_en === 1'b1 && sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         if (cq.rf_write_address !== e.rd || cq.rf_write_data !== e.data) begin
            errors++;
            $display("FAIL commit_entry: got %0d/%h expected %0d/%h",
                     cq.rf_write_address, cq.rf_write_data, e.rd, e.data);
         end
      end
   end

   function automatic void model_ready(output bit ar, output bit lr);
      int unsigned pop;
      int unsigned free;
      pop  = (m_count != 0) ? 1 : 0;
      free = DEPTH - m_count + pop;
      ar   = (free >= 1);
      lr   = cq.alu_valid ? (free >= 2) : (free >= 1);
   endfunction

   function automatic void model_fwd(input logic [AW-1:0] a, output logic hit,
                                     output logic [DW-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (a != '0) begin
         foreach (sb[i]) begin
            if (sb[i].rd == a) begin
               hit = 1'b1;
               d   = sb[i].data;
            end
         end
      end
   endfunction

   // Clock edge plus reference-model update; returns 1 ns after the edge.
   task automatic advance();
      bit ar;
      bit lr;
      int unsigned pop;
      @(posedge clk);
      model_ready(ar, lr);
      pop        = (m_count != 0) ? 1 : 0;
      last_a_acc = cq.alu_valid && ar;
      last_l_acc = cq.ld_valid && lr;
      if (last_a_acc && cq.alu_rd != '0) begin
         sb.push_back('{cq.alu_rd, cq.alu_data});
         m_count++;
      end
      if (last_l_acc && cq.ld_rd != '0) begin
         sb.push_back('{cq.ld_rd, cq.ld_data});
         m_count++;
      end
      m_count = m_count - pop;
      #1;
   endtask

   task automatic idle_inputs();
      cq.alu_valid  = 1'b0;
      cq.alu_rd     = '0;
      cq.alu_data   = '0;
      cq.ld_valid   = 1'b0;
      cq.ld_rd      = '0;
      cq.ld_data    = '0;
   endtask

   task automatic test_reset();
      cq.fwd_addr_0 = 5'd1;
      cq.fwd_addr_1 = 5'd2;
      #2;
      checks++;
      if (cq.rf_write_en !== 1'b0 || cq.rf_write_address !== '0 || cq.rf_write_data !== '0
          || cq.count !== '0 || cq.fwd_hit_0 !== 1'b0 || cq.fwd_hit_1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got en=%b a=%0d d=%h cnt=%0d h0=%b h1=%b expected all zero",
                  cq.rf_write_en, cq.rf_write_address, cq.rf_write_data, cq.count,
                  cq.fwd_hit_0, cq.fwd_hit_1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      cq.alu_valid = 1'b1;
      cq.alu_rd    = 5'd5;
      cq.alu_data  = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (cq.alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: got %b expected 1", cq.alu_ready);
      end
      checks++;
      if (cq.rf_write_en !== 1'b0) begin
         errors++;
         $display("FAIL single_nobypass: got %b expected 0", cq.rf_write_en);
      end
      advance();
      idle_inputs();
      #1;
      checks++;
      if (cq.rf_write_en !== 1'b1 || cq.rf_write_address !== 5'd5 || cq.rf_write_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_write: got %b/%0d/%h expected 1/5/deadbeef",
                  cq.rf_write_en, cq.rf_write_address, cq.rf_write_data);
      end
      advance();
      checks++;
      if (cq.rf_write_en !== 1'b0 || cq.count !== '0) begin
         errors++;
         $display("FAIL single_after: got en=%b cnt=%0d expected 0/0", cq.rf_write_en, cq.count);
      end
   endtask

   task automatic test_same_rd();
      cq.alu_valid = 1'b1; cq.alu_rd = 5'd3; cq.alu_data = 32'h11;
      cq.ld_valid  = 1'b1; cq.ld_rd  = 5'd3; cq.ld_data  = 32'h22;
      #1;
      checks++;
      if (cq.alu_ready !== 1'b1 || cq.ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL pair_ready: got %b%b expected 11", cq.alu_ready, cq.ld_ready);
      end
      advance();
      idle_inputs();
      cq.fwd_addr_0 = 5'd3;
      cq.fwd_addr_1 = 5'd7;
      #1;
      checks++;
      if (cq.count !== CW'(2) || cq.fwd_hit_0 !== 1'b1 || cq.fwd_data_0 !== 32'h22) begin
         errors++;
         $display("FAIL pair_fwd: got cnt=%0d hit=%b data=%h expected 2/1/22",
                  cq.count, cq.fwd_hit_0, cq.fwd_data_0);
      end
      checks++;
      if (cq.fwd_hit_1 !== 1'b0 || cq.fwd_data_1 !== '0) begin
         errors++;
         $display("FAIL pair_fwd_miss: got %b/%h expected 0/0", cq.fwd_hit_1, cq.fwd_data_1);
      end
      checks++;
      if (cq.rf_write_data !== 32'h11) begin
         errors++;
         $display("FAIL pair_first: got %h expected 11", cq.rf_write_data);
      end
      advance();
      checks++;
      if (cq.rf_write_en !== 1'b1 || cq.rf_write_data !== 32'h22) begin
         errors++;
         $display("FAIL pair_second: got %b/%h expected 1/22", cq.rf_write_en, cq.rf_write_data);
      end
      advance();
      checks++;
      if (cq.count !== '0) begin
         errors++;
         $display("FAIL pair_drained: got %0d expected 0", cq.count);
      end
   endtask

   task automatic test_reg_zero();
      cq.alu_valid  = 1'b1; cq.alu_rd = 5'd0; cq.alu_data = 32'hFFFF_FFFF;
      cq.fwd_addr_0 = 5'd0;
      #1;
      checks++;
      if (cq.alu_ready !== 1'b1 || cq.fwd_hit_0 !== 1'b0 || cq.fwd_data_0 !== '0) begin
         errors++;
         $display("FAIL r0_ready: got rdy=%b hit=%b data=%h expected 1/0/0",
                  cq.alu_ready, cq.fwd_hit_0, cq.fwd_data_0);
      end
      advance();
      idle_inputs();
      #1;
      checks++;
      if (cq.count !== '0 || cq.rf_write_en !== 1'b0) begin
         errors++;
         $display("FAIL r0_dropped: got cnt=%0d en=%b expected 0/0", cq.count, cq.rf_write_en);
      end
      // r0 ALU still forces the two-slot rule on the load, but only the load enqueues.
      cq.alu_valid = 1'b1; cq.alu_rd = 5'd0; cq.alu_data = 32'h1234;
      cq.ld_valid  = 1'b1; cq.ld_rd  = 5'd9; cq.ld_data  = 32'h9999;
      advance();
      idle_inputs();
      #1;
      checks++;
      if (cq.count !== CW'(1) || cq.rf_write_address !== 5'd9) begin
         errors++;
         $display("FAIL r0_mixed: got cnt=%0d addr=%0d expected 1/9", cq.count, cq.rf_write_address);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      int unsigned seq;
      bit ar;
      bit lr;
      logic h;
      logic [DW-1:0] d;
      int unsigned exp_cnt[8] = '{2, 3, 4, 4, 4, 4, 4, 4};
      seq = 1;
      cq.alu_valid = 1'b1; cq.alu_rd = AW'(seq);     cq.alu_data = 32'hA000_0000 + seq;
      cq.ld_valid  = 1'b1; cq.ld_rd  = AW'(seq + 1); cq.ld_data  = 32'hB000_0000 + seq + 1;
      seq = seq + 2;
      for (int c = 0; c < 8; c++) begin
         cq.fwd_addr_0 = cq.alu_rd - 5'd1;
         cq.fwd_addr_1 = cq.alu_rd - 5'd2;
         #1;
         model_ready(ar, lr);
         checks++;
         if (cq.alu_ready !== ar || cq.ld_ready !== lr) begin
            errors++;
            $display("FAIL b2b_ready[%0d]: got %b%b expected %b%b", c, cq.alu_ready, cq.ld_ready, ar, lr);
         end
         model_fwd(cq.fwd_addr_0, h, d);
         checks++;
         if (cq.fwd_hit_0 !== h || cq.fwd_data_0 !== d) begin
            errors++;
            $display("FAIL b2b_fwd0[%0d]: got %b/%h expected %b/%h", c, cq.fwd_hit_0, cq.fwd_data_0, h, d);
         end
         model_fwd(cq.fwd_addr_1, h, d);
         checks++;
         if (cq.fwd_hit_1 !== h || cq.fwd_data_1 !== d) begin
            errors++;
            $display("FAIL b2b_fwd1[%0d]: got %b/%h expected %b/%h", c, cq.fwd_hit_1, cq.fwd_data_1, h, d);
         end
         advance();
         checks++;
         if (cq.count !== CW'(exp_cnt[c])) begin
            errors++;
            $display("FAIL b2b_count[%0d]: got %0d expected %0d", c, cq.count, exp_cnt[c]);
         end
         if (last_a_acc) begin
            cq.alu_rd = AW'(seq); cq.alu_data = 32'hA000_0000 + seq; seq++;
         end
         if (last_l_acc) begin
            cq.ld_rd = AW'(seq); cq.ld_data = 32'hB000_0000 + seq; seq++;
         end
      end
      idle_inputs();
      for (int k = 0; k < 20 && m_count != 0; k++) advance();
      checks++;
      if (cq.count !== '0 || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got cnt=%0d pending=%0d expected 0/0", cq.count, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      cq.alu_valid = 1'b1; cq.alu_rd = 5'd10; cq.alu_data = 32'h1010;
      cq.ld_valid  = 1'b1; cq.ld_rd  = 5'd11; cq.ld_data  = 32'h1111;
      advance();
      cq.alu_rd = 5'd12; cq.alu_data = 32'h1212;
      cq.ld_rd  = 5'd13; cq.ld_data  = 32'h1313;
      advance();
      idle_inputs();
      #1;
      checks++;
      if (cq.count !== CW'(3)) begin
         errors++;
         $display("FAIL rstmid_fill: got %0d expected 3", cq.count);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (cq.rf_write_en !== 1'b0 || cq.count !== '0) begin
         errors++;
         $display("FAIL rstmid_async: got en=%b cnt=%0d expected 0/0", cq.rf_write_en, cq.count);
      end
      sb.delete();
      m_count = 0;
      advance();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         advance();
         checks++;
         if (cq.rf_write_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet[%0d]: got %b expected 0", c, cq.rf_write_en);
         end
      end
      cq.alu_valid = 1'b1; cq.alu_rd = 5'd14; cq.alu_data = 32'h1414;
      advance();
      idle_inputs();
      #1;
      checks++;
      if (cq.rf_write_en !== 1'b1 || cq.rf_write_address !== 5'd14) begin
         errors++;
         $display("FAIL rstmid_resume: got %b/%0d expected 1/14", cq.rf_write_en, cq.rf_write_address);
      end
      advance();
   endtask

   task automatic test_streaming();
      bit ar;
      bit lr;
      logic h;
      logic [DW-1:0] d;
      for (int c = 0; c < 6 * DEPTH; c++) begin
         cq.alu_valid  = 1'($urandom_range(0, 1));
         cq.alu_rd     = AW'($urandom_range(0, 7));
         cq.alu_data   = $urandom;
         cq.ld_valid   = 1'($urandom_range(0, 1));
         cq.ld_rd      = AW'($urandom_range(0, 7));
         cq.ld_data    = $urandom;
         cq.fwd_addr_0 = AW'($urandom_range(0, 7));
         cq.fwd_addr_1 = AW'($urandom_range(0, 7));
         #1;
         model_ready(ar, lr);
         checks++;
         if (cq.alu_ready !== ar || cq.ld_ready !== lr || cq.count !== CW'(m_count)) begin
            errors++;
            $display("FAIL stream_state[%0d]: got rdy=%b%b cnt=%0d expected %b%b/%0d",
                     c, cq.alu_ready, cq.ld_ready, cq.count, ar, lr, m_count);
         end
         model_fwd(cq.fwd_addr_0, h, d);
         checks++;
         if (cq.fwd_hit_0 !== h || cq.fwd_data_0 !== d) begin
            errors++;
            $display("FAIL stream_fwd0[%0d]: got %b/%h expected %b/%h", c, cq.fwd_hit_0, cq.fwd_data_0, h, d);
         end
         model_fwd(cq.fwd_addr_1, h, d);
         checks++;
         if (cq.fwd_hit_1 !== h || cq.fwd_data_1 !== d) begin
            errors++;
            $display("FAIL stream_fwd1[%0d]: got %b/%h expected %b/%h", c, cq.fwd_hit_1, cq.fwd_data_1, h, d);
         end
         advance();
      end
      idle_inputs();
      for (int k = 0; k < 20 && m_count != 0; k++) advance();
      checks++;
      if (cq.count !== '0 || sb.size() != 0) begin
         errors++;
         $display("FAIL stream_drain: got cnt=%0d pending=%0d expected 0/0", cq.count, sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clk     = 1'b0;
      rst_n   = 1'b1;
      checks  = 0;
      errors  = 0;
      m_count = 0;
      idle_inputs();
      cq.fwd_addr_0 = '0;
      cq.fwd_addr_1 = '0;
      #1 rst_n = 1'b0;
      test_reset();
      test_single();
      test_same_rd();
      test_reg_zero();
      test_back_to_back();
      test_reset_mid();
      test_streaming();
      #20;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
